// File: rtl/alu_decode_stage.sv
// RV32I decode/operand-fetch stage feeding the ALU.
// Holds the 32x32 register file with write-back bypass into operand fetch.
module alu_decode_stage #(
   parameter int WIDTH    = 32,
   parameter int OP_WIDTH = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         instr,
   input  logic                wb_en,
   input  logic [4:0]          wb_rd,
   input  logic [WIDTH-1:0]    wb_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OP_WIDTH-1:0] opcode,
   output logic [WIDTH-1:0]    a,
   output logic [WIDTH-1:0]    b,
   output logic [4:0]          rd,
   output logic                illegal
);

   logic [WIDTH-1:0]    rf_q [32];
   logic                out_valid_q;
   logic [OP_WIDTH-1:0] opcode_q, opcode_d;
   logic [WIDTH-1:0]    a_q, a_d;
   logic [WIDTH-1:0]    b_q, b_d;
   logic [4:0]          rd_q, rd_d;
   logic                illegal_q, illegal_d;

   logic                accept;
   logic [4:0]          rs1, rs2, rd_f;
   logic [2:0]          f3;
   logic [6:0]          f7;
   logic                is_r, is_i;
   logic [WIDTH-1:0]    rs1_val, rs2_val;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   assign rs1  = instr[19:15];
   assign rs2  = instr[24:20];
   assign rd_f = instr[11:7];
   assign f3   = instr[14:12];
   assign f7   = instr[31:25];
   assign is_r = instr[6:0] == 7'b0110011;
   assign is_i = instr[6:0] == 7'b0010011;

   // Operand fetch: x0 is hardwired, a same-cycle write-back wins over the array
   always_comb begin
      rs1_val = rf_q[rs1];
      rs2_val = rf_q[rs2];
      if (wb_en && wb_rd == rs1) rs1_val = wb_data;
      if (wb_en && wb_rd == rs2) rs2_val = wb_data;
      if (rs1 == 5'd0) rs1_val = '0;
      if (rs2 == 5'd0) rs2_val = '0;
   end

   // Decode the instruction into the next ALU bundle; illegal forms emit zeros
   always_comb begin
      logic             legal;
      logic             bit4;
      logic [WIDTH-1:0] bval;
      legal     = 1'b0;
      bit4      = 1'b0;
      bval      = '0;
      opcode_d  = '0;
      a_d       = '0;
      b_d       = '0;
      rd_d      = '0;
      illegal_d = 1'b1;
      unique case (1'b1)
         is_r: begin
            legal = (f7 == 7'b0000000) ||
                    (f7 == 7'b0100000 &&
                     (f3 == 3'b000 || f3 == 3'b101));
            bit4  = f7[5];
            bval  = rs2_val;
         end
         is_i: begin
            if (f3 == 3'b001) begin
               legal = f7 == 7'b0000000;
               bval  = {{(WIDTH-5){1'b0}}, instr[24:20]};
            end else if (f3 == 3'b101) begin
               legal = (f7 == 7'b0000000) ||
                       (f7 == 7'b0100000);
               bit4  = instr[30];
               bval  = {{(WIDTH-5){1'b0}}, instr[24:20]};
            end else begin
               legal = 1'b1;
               bval  = {{(WIDTH-12){instr[31]}}, instr[31:20]};
            end
         end
         default: legal = 1'b0;
      endcase
      if (legal) begin
         opcode_d  = OP_WIDTH'({bit4, f3, 1'b1});
         a_d       = rs1_val;
         b_d       = bval;
         rd_d      = rd_f;
         illegal_d = 1'b0;
      end
   end

   // Register file: write-back commits regardless of handshake, x0 never written
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (wb_en && wb_rd != 5'd0) begin
         rf_q[wb_rd] <= wb_data;
      end
   end

   // Output bundle: load on accept, hold while stalled, drop valid when drained
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         opcode_q    <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rd_q        <= '0;
         illegal_q   <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         opcode_q    <= opcode_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rd_q        <= rd_d;
         illegal_q   <= illegal_d;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign opcode    = opcode_q;
   assign a         = a_q;
   assign b         = b_q;
   assign rd        = rd_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage.
// Directed plan items followed by randomized traffic against a reference model.
module tb_alu_decode_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  opcode;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  rd;
   logic        illegal;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [31:0] m_rf [32];
   logic        m_v;
   logic [4:0]  m_op;
   logic [31:0] m_a;
   logic [31:0] m_b;
   logic [4:0]  m_rd;
   logic        m_ill;

   alu_decode_stage #(.WIDTH(32), .OP_WIDTH(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .wb_en     (wb_en),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .opcode    (opcode),
      .a         (a),
      .b         (b),
      .rd        (rd),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input int f7, input int rs2,
                                         input int rs1, input int f3,
                                         input int rdi);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rdi), 7'h33};
   endfunction

   function automatic logic [31:0] itype(input int imm, input int rs1,
                                         input int f3, input int rdi);
      return {12'(imm), 5'(rs1), 3'(f3), 5'(rdi), 7'h13};
   endfunction

   // register read as seen by operand fetch, including write-back forwarding
   function automatic logic [31:0] rv(input logic [4:0] r, input logic we,
                                      input logic [4:0] wrd,
                                      input logic [31:0] wd);
      if (r == 5'd0) return 32'h0;
      if (we && wrd == r) return wd;
      return m_rf[r];
   endfunction

   // decode from the ISA rules: opcode = 16*alt + 2*funct3 + 1
   task automatic ref_dec(input logic [31:0] ins, input logic [31:0] av,
                          input logic [31:0] bv);
      int maj = int'(ins[6:0]);
      int f3  = int'(ins[14:12]);
      int f7  = int'(ins[31:25]);
      int imm = int'(ins[31:20]);
      bit ok  = 0;
      int alt = 0;
      logic [31:0] bb = 32'h0;
      if (maj == 51) begin
         ok  = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
         alt = (f7 == 32) ? 1 : 0;
         bb  = bv;
      end else if (maj == 19) begin
         if (f3 == 1 || f3 == 5) begin
            ok  = (f7 == 0) || (f3 == 5 && f7 == 32);
            alt = (f7 == 32) ? 1 : 0;
            bb  = 32'(int'(ins[24:20]));
         end else begin
            ok = 1;
            if (imm >= 2048) imm -= 4096;
            bb = 32'(imm);
         end
      end
      if (ok) begin
         m_op  = 5'(alt * 16 + f3 * 2 + 1);
         m_a   = av;
         m_b   = bb;
         m_rd  = ins[11:7];
         m_ill = 1'b0;
      end else begin
         m_op  = 5'd0;
         m_a   = 32'h0;
         m_b   = 32'h0;
         m_rd  = 5'd0;
         m_ill = 1'b1;
      end
   endtask

   task automatic chk_out();
      chk("out_valid", 32'(out_valid), 32'(m_v));
      if (m_v) begin
         chk("opcode", 32'(opcode), 32'(m_op));
         chk("a", a, m_a);
         chk("b", b, m_b);
         chk("rd", 32'(rd), 32'(m_rd));
         chk("illegal", 32'(illegal), 32'(m_ill));
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_v = 0; m_op = 0; m_a = 0; m_b = 0; m_rd = 0; m_ill = 0;
   endtask

   // one clock: drive at negedge, check in_ready, update model, check at next negedge
   task automatic step(input logic iv, input logic [31:0] ins,
                       input logic we, input logic [4:0] wrd,
                       input logic [31:0] wd, input logic ordy);
      logic rdy;
      in_valid  = iv;
      instr     = ins;
      wb_en     = we;
      wb_rd     = wrd;
      wb_data   = wd;
      out_ready = ordy;
      #1;
      rdy = !m_v || ordy;
      chk("in_ready", 32'(in_ready), 32'(rdy));
      @(posedge clk);
      if (iv && rdy) begin
         ref_dec(ins, rv(ins[19:15], we, wrd, wd), rv(ins[24:20], we, wrd, wd));
         m_v = 1'b1;
      end else if (ordy) begin
         m_v = 1'b0;
      end
      if (we && wrd != 5'd0) m_rf[wrd] = wd;
      @(negedge clk);
      chk_out();
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, ordy);
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] d);
      step(1'b0, 32'h0, 1'b1, r, d, 1'b1);
   endtask

   task automatic issue(input logic [31:0] ins);
      step(1'b1, ins, 1'b0, 5'd0, 32'h0, 1'b1);
   endtask

   function automatic logic [31:0] rand_instr();
      int k   = int'($urandom_range(0, 9));
      int sel = int'($urandom_range(0, 3));
      int f7  = (sel == 0) ? 32 : (sel == 3) ? int'($urandom_range(0, 127)) : 0;
      int f3  = int'($urandom_range(0, 7));
      int r1  = int'($urandom_range(0, 7));
      int r2  = int'($urandom_range(0, 7));
      int rdi = int'($urandom_range(0, 31));
      int imm = int'($urandom_range(0, 4095));
      logic [31:0] w;
      if (k <= 3) return rtype(f7, r2, r1, f3, rdi);
      if (k <= 7) begin
         w = itype(imm, r1, f3, rdi);
         if (f3 == 1 || f3 == 5) w[31:25] = 7'(f7);
         return w;
      end
      w = $urandom;
      if (k == 9) w[6:0] = 7'h33;
      return w;
   endfunction

   initial begin
      logic [31:0] add_x3 = 32'h002081B3;
      logic [31:0] sub_x5 = 32'h402082B3;
      model_reset();
      rst = 1'b1;
      in_valid = 0; instr = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
      out_ready = 1;
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_opcode", 32'(opcode), 32'h0);
      chk("rst_a", a, 32'h0);
      chk("rst_b", b, 32'h0);
      chk("rst_rd", 32'(rd), 32'h0);
      chk("rst_illegal", 32'(illegal), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      rst = 1'b0;
      @(negedge clk);

      wb(5'd1, 32'haa554422);
      wb(5'd2, 32'h00993300);
      issue(add_x3);
      chk("add_op", 32'(opcode), 32'h01);
      chk("add_a", a, 32'haa554422);
      chk("add_b", b, 32'h00993300);
      chk("add_rd", 32'(rd), 32'd3);
      issue(sub_x5);
      chk("sub_op", 32'(opcode), 32'h11);
      chk("sub_rd", 32'(rd), 32'd5);
      issue(32'hFFF08213);
      chk("addi_op", 32'(opcode), 32'h01);
      chk("addi_b", b, 32'hFFFFFFFF);
      chk("addi_rd", 32'(rd), 32'd4);
      issue(32'h40315093);
      chk("srai_op", 32'(opcode), 32'h1B);
      chk("srai_b", b, 32'h00000003);
      idle(1'b1);

      // backpressure: bundle held, second instruction refused until drained
      step(1'b1, add_x3, 1'b0, 5'd0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, sub_x5, 1'b0, 5'd0, 32'h0, 1'b0);
         chk("hold_op", 32'(opcode), 32'h01);
         chk("hold_rd", 32'(rd), 32'd3);
      end
      step(1'b1, sub_x5, 1'b0, 5'd0, 32'h0, 1'b1);
      chk("bp_second_op", 32'(opcode), 32'h11);
      chk("bp_second_rd", 32'(rd), 32'd5);
      idle(1'b1);

      // bypass of a same-cycle write-back
      step(1'b1, add_x3, 1'b1, 5'd1, 32'h12345678, 1'b1);
      chk("byp_a", a, 32'h12345678);
      step(1'b1, rtype(0, 2, 0, 0, 3), 1'b1, 5'd0, 32'hdeadbeef, 1'b1);
      chk("byp_x0_a", a, 32'h0);
      issue(rtype(0, 0, 1, 0, 6));
      chk("x0_read_b", b, 32'h0);
      chk("x1_read_a", a, 32'h12345678);

      // illegal encodings
      issue(32'h00000000);
      chk("ill0_flag", 32'(illegal), 32'h1);
      chk("ill0_op", 32'(opcode), 32'h0);
      issue(32'h022081B3);
      chk("ill_mul_flag", 32'(illegal), 32'h1);
      chk("ill_mul_a", a, 32'h0);
      chk("ill_mul_rd", 32'(rd), 32'h0);
      idle(1'b1);

      // asynchronous reset during a stall
      step(1'b1, add_x3, 1'b0, 5'd0, 32'h0, 1'b0);
      idle(1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      chk("arst_valid", 32'(out_valid), 32'h0);
      chk("arst_in_ready", 32'(in_ready), 32'h1);
      chk("arst_a", a, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(add_x3);
      chk("post_rst_x1", a, 32'h0);
      chk("post_rst_x2", b, 32'h0);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         step(1'($urandom_range(0, 3) != 0), rand_instr(),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              $urandom, 1'($urandom_range(0, 3) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
